// File: rtl/shift_pkg.sv
// Shared helpers for the parametrised shift delay line: derived widths and the stage index type.
package shift_pkg;

  typedef int unsigned stage_idx_t;

  // Tap select width; a 1-bit select is kept even for degenerate depths.
  function automatic int tap_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One stage of the delay line: WIDTH-bit data register plus its valid bit.
module shift_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_vld,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
);

  // Clearing valid leaves the data word untouched; flush only invalidates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q     <= '0;
      q_vld <= 1'b0;
    end else if (clr_vld) begin
      q_vld <= 1'b0;
    end else if (en) begin
      q     <= d;
      q_vld <= d_vld;
    end
  end

endmodule

// File: rtl/param_shift_line.sv
// Parametrised DEPTH-stage shift delay line with read tap, flush and optional occupancy tracking.
// Define SHIFT_OCC_EN to add the occ/full/empty ports and the occupancy counter.
module param_shift_line
  import shift_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 9,
  localparam int TAP_W = tap_w(DEPTH),
  localparam int OCC_W = occ_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shn,
  input  logic             flush,
  input  logic [WIDTH-1:0] si,
  input  logic             si_vld,
  input  logic [TAP_W-1:0] tap_sel,
  output logic [WIDTH-1:0] so,
  output logic             so_vld,
  output logic             so_take,
  output logic [WIDTH-1:0] so_tap,
  output logic             tap_vld
`ifdef SHIFT_OCC_EN
  ,
  output logic [OCC_W-1:0] occ,
  output logic             full,
  output logic             empty
`endif
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0]            vld_q;
  logic                        shift_en;

  assign shift_en = shn & ~flush;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      shift_stage #(.WIDTH(WIDTH)) u_stage (
        .clk(clk), .rst(rst), .en(shift_en), .clr_vld(flush),
        .d(si), .d_vld(si_vld), .q(data_q[g]), .q_vld(vld_q[g])
      );
    end else begin : g_body
      shift_stage #(.WIDTH(WIDTH)) u_stage (
        .clk(clk), .rst(rst), .en(shift_en), .clr_vld(flush),
        .d(data_q[g-1]), .d_vld(vld_q[g-1]), .q(data_q[g]), .q_vld(vld_q[g])
      );
    end
  end

  assign so      = data_q[DEPTH-1];
  assign so_vld  = vld_q[DEPTH-1];
  assign so_take = shift_en & vld_q[DEPTH-1];

  // Out-of-range selects match no stage and fall through to the zero default.
  always_comb begin
    so_tap  = '0;
    tap_vld = 1'b0;
    for (stage_idx_t i = 0; i < stage_idx_t'(DEPTH); i++) begin
      if (tap_sel == TAP_W'(i)) begin
        so_tap  = data_q[i];
        tap_vld = vld_q[i];
      end
    end
  end

`ifdef SHIFT_OCC_EN
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             enter;

  assign enter = shn & si_vld;

  // A word entering while another leaves keeps the count unchanged.
  always_comb begin
    occ_d = occ_q;
    if (flush)                 occ_d = '0;
    else if (enter && !so_take) occ_d = occ_q + 1'b1;
    else if (!enter && so_take) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) occ_q <= '0;
    else      occ_q <= occ_d;
  end

  assign occ   = occ_q;
  assign full  = (occ_q == OCC_W'(DEPTH));
  assign empty = (occ_q == '0);
`endif

endmodule
